// File: rtl/mac_stream_feeder.sv
// mac_stream_feeder: buffers up to DEPTH input/kernel word pairs, streams
// them with a bias word into the MAC compute path and captures the result.
//
// Ports:
//   clk, reset                  clock, async active-high reset
//   wr_en, wr_i, wr_k, wr_full  pair buffer loader (accepted only in idle)
//   bias, start                 job launch, bias sampled on accepted start
//   busy, done, result          job status and captured result word
//   b_T*, i_T*, k_T*            bias / input / kernel stream sources
//   new_i                       high while pairs of the job remain to send
//   o_T*                        result stream sink
module mac_stream_feeder #(
   parameter int DATA_W = 8,
   parameter int OUT_W  = 32,
   parameter int DEPTH  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_i,
   input  logic [DATA_W-1:0] wr_k,
   output logic              wr_full,
   input  logic [DATA_W-1:0] bias,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic [OUT_W-1:0]  result,
   output logic [DATA_W-1:0] i_TDATA,
   output logic              i_TVALID,
   input  logic              i_TREADY,
   output logic [DATA_W-1:0] k_TDATA,
   output logic              k_TVALID,
   input  logic              k_TREADY,
   output logic [DATA_W-1:0] b_TDATA,
   output logic              b_TVALID,
   input  logic              b_TREADY,
   output logic              new_i,
   input  logic [OUT_W-1:0]  o_TDATA,
   input  logic              o_TVALID,
   output logic              o_TREADY
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);
   localparam logic [AW:0] C_ONE = (AW+1)'(1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SEND,
      S_WAIT_O
   } state_t;

   state_t r_state;
   state_t w_state_n;

   logic [DATA_W-1:0] r_buf_i [DEPTH];
   logic [DATA_W-1:0] r_buf_k [DEPTH];

   logic [AW:0]       r_cnt;
   logic [AW:0]       w_cnt_n;
   logic [AW-1:0]     r_rd;
   logic [AW-1:0]     w_rd_n;
   logic              r_b_valid;
   logic              w_b_valid_n;
   logic              r_p_valid;
   logic              w_p_valid_n;
   logic [DATA_W-1:0] r_b_data;
   logic [DATA_W-1:0] w_b_data_n;
   logic [DATA_W-1:0] r_i_data;
   logic [DATA_W-1:0] w_i_data_n;
   logic [DATA_W-1:0] r_k_data;
   logic [DATA_W-1:0] w_k_data_n;
   logic [OUT_W-1:0]  r_result;
   logic [OUT_W-1:0]  w_result_n;
   logic              r_done;
   logic              w_done_n;

   logic              w_wr;
   logic              w_full;
   logic              w_b_xfer;
   logic              w_p_xfer;
   logic              w_last;
   logic [AW-1:0]     w_rd_inc;

   assign w_full   = (r_cnt == C_DEPTH);
   assign w_b_xfer = r_b_valid & b_TREADY;
   // i and k share one valid; a pair moves only when both sides accept
   assign w_p_xfer = r_p_valid & i_TREADY & k_TREADY;
   assign w_last   = ({1'b0, r_rd} == (r_cnt - C_ONE));
   assign w_rd_inc = r_rd + AW'(1);

   always_comb begin
      w_state_n   = r_state;
      w_cnt_n     = r_cnt;
      w_rd_n      = r_rd;
      w_b_valid_n = r_b_valid;
      w_p_valid_n = r_p_valid;
      w_b_data_n  = r_b_data;
      w_i_data_n  = r_i_data;
      w_k_data_n  = r_k_data;
      w_result_n  = r_result;
      w_done_n    = 1'b0;
      w_wr        = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (start && (r_cnt != '0)) begin
               // pair data is preloaded so TDATA is a plain register
               w_b_data_n  = bias;
               w_rd_n      = '0;
               w_i_data_n  = r_buf_i[0];
               w_k_data_n  = r_buf_k[0];
               w_b_valid_n = 1'b1;
               w_p_valid_n = 1'b1;
               w_state_n   = S_SEND;
            end else if (wr_en && !w_full) begin
               w_wr    = 1'b1;
               w_cnt_n = r_cnt + C_ONE;
            end
         end
         S_SEND: begin
            if (w_b_xfer) begin
               w_b_valid_n = 1'b0;
            end
            if (w_p_xfer) begin
               if (w_last) begin
                  w_p_valid_n = 1'b0;
               end else begin
                  w_rd_n     = w_rd_inc;
                  w_i_data_n = r_buf_i[w_rd_inc];
                  w_k_data_n = r_buf_k[w_rd_inc];
               end
            end
            // bias and pairs may finish in either order
            if (!w_b_valid_n && !w_p_valid_n) begin
               w_state_n = S_WAIT_O;
            end
         end
         S_WAIT_O: begin
            if (o_TVALID) begin
               w_result_n = o_TDATA;
               w_done_n   = 1'b1;
               w_cnt_n    = '0;
               w_state_n  = S_IDLE;
            end
         end
         default: begin
            w_state_n = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_n;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt     <= '0;
         r_rd      <= '0;
         r_b_valid <= 1'b0;
         r_p_valid <= 1'b0;
         r_b_data  <= '0;
         r_i_data  <= '0;
         r_k_data  <= '0;
         r_result  <= '0;
         r_done    <= 1'b0;
      end else begin
         r_cnt     <= w_cnt_n;
         r_rd      <= w_rd_n;
         r_b_valid <= w_b_valid_n;
         r_p_valid <= w_p_valid_n;
         r_b_data  <= w_b_data_n;
         r_i_data  <= w_i_data_n;
         r_k_data  <= w_k_data_n;
         r_result  <= w_result_n;
         r_done    <= w_done_n;
      end
   end

   // storage needs no reset: the pair count alone marks valid entries
   always_ff @(posedge clk) begin
      if (w_wr) begin
         r_buf_i[r_cnt[AW-1:0]] <= wr_i;
         r_buf_k[r_cnt[AW-1:0]] <= wr_k;
      end
   end

   assign wr_full  = w_full;
   assign busy     = (r_state != S_IDLE);
   assign done     = r_done;
   assign result   = r_result;
   assign b_TDATA  = r_b_data;
   assign b_TVALID = r_b_valid;
   assign i_TDATA  = r_i_data;
   assign i_TVALID = r_p_valid;
   assign k_TDATA  = r_k_data;
   assign k_TVALID = r_p_valid;
   assign new_i    = r_p_valid;
   assign o_TREADY = (r_state == S_WAIT_O);

endmodule

// File: tb/tb_mac_stream_feeder.sv
// tb_mac_stream_feeder: directed stimulus with a queue scoreboard; a
// negedge monitor pops expected pairs, bias and results as they appear.
`timescale 1ns/1ps
module tb_mac_stream_feeder;

   logic        clk = 1'b0;
   logic        reset;
   logic        wr_en;
   logic [7:0]  wr_i;
   logic [7:0]  wr_k;
   logic        wr_full;
   logic [7:0]  bias;
   logic        start;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic [7:0]  i_TDATA;
   logic        i_TVALID;
   logic        i_TREADY;
   logic [7:0]  k_TDATA;
   logic        k_TVALID;
   logic        k_TREADY;
   logic [7:0]  b_TDATA;
   logic        b_TVALID;
   logic        b_TREADY;
   logic        new_i;
   logic [31:0] o_TDATA;
   logic        o_TVALID;
   logic        o_TREADY;

   int n_err = 0;
   int n_checks = 0;
   int mcnt = 0;

   logic [7:0]  exp_i [$];
   logic [7:0]  exp_k [$];
   logic [7:0]  exp_b [$];
   logic [31:0] exp_r [$];

   always #5 clk = ~clk;

   mac_stream_feeder #(
      .DATA_W(8),
      .OUT_W (32),
      .DEPTH (16)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_en),
      .wr_i    (wr_i),
      .wr_k    (wr_k),
      .wr_full (wr_full),
      .bias    (bias),
      .start   (start),
      .busy    (busy),
      .done    (done),
      .result  (result),
      .i_TDATA (i_TDATA),
      .i_TVALID(i_TVALID),
      .i_TREADY(i_TREADY),
      .k_TDATA (k_TDATA),
      .k_TVALID(k_TVALID),
      .k_TREADY(k_TREADY),
      .b_TDATA (b_TDATA),
      .b_TVALID(b_TVALID),
      .b_TREADY(b_TREADY),
      .new_i   (new_i),
      .o_TDATA (o_TDATA),
      .o_TVALID(o_TVALID),
      .o_TREADY(o_TREADY)
   );

   task automatic check(input string nm, input logic [63:0] act,
                        input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic miss(input string nm);
      n_checks++;
      n_err++;
      $display("FAIL %s: got event, expected none", nm);
   endtask

   // ---------------- monitor ----------------
   logic       pv_prev = 1'b0;
   logic       px_prev = 1'b0;
   logic       bv_prev = 1'b0;
   logic       bx_prev = 1'b0;
   logic       dn_prev = 1'b0;
   logic [7:0] pi_prev = '0;
   logic [7:0] pk_prev = '0;
   logic [7:0] pb_prev = '0;

   always @(negedge clk) begin
      logic px;
      logic bx;
      logic [7:0] e8;
      logic [31:0] e32;
      if (reset) begin
         pv_prev = 1'b0;
         px_prev = 1'b0;
         bv_prev = 1'b0;
         bx_prev = 1'b0;
         dn_prev = 1'b0;
      end else begin
         if (busy)
            check("ik_lockstep", 64'({i_TVALID, new_i}),
                  64'({k_TVALID, k_TVALID}));
         if (pv_prev && !px_prev)
            check("ik_hold", 64'({i_TVALID, i_TDATA, k_TDATA}),
                  64'({1'b1, pi_prev, pk_prev}));
         if (bv_prev && !bx_prev)
            check("b_hold", 64'({b_TVALID, b_TDATA}),
                  64'({1'b1, pb_prev}));
         px = i_TVALID & i_TREADY & k_TREADY;
         bx = b_TVALID & b_TREADY;
         if (px) begin
            if (exp_i.size() == 0) miss("extra_pair");
            else begin
               e8 = exp_i.pop_front();
               check("pair_i", 64'(i_TDATA), 64'(e8));
               e8 = exp_k.pop_front();
               check("pair_k", 64'(k_TDATA), 64'(e8));
            end
         end
         if (bx) begin
            if (exp_b.size() == 0) miss("extra_bias");
            else begin
               e8 = exp_b.pop_front();
               check("bias", 64'(b_TDATA), 64'(e8));
            end
         end
         if (o_TREADY)
            check("wait_o_quiet",
                  64'({b_TVALID, i_TVALID, new_i, exp_i.size() != 0,
                       exp_b.size() != 0}), 64'(0));
         if (done) begin
            check("done_one_cycle", 64'(dn_prev), 64'(0));
            check("busy_after_done", 64'(busy), 64'(0));
            if (exp_r.size() == 0) miss("extra_done");
            else begin
               e32 = exp_r.pop_front();
               check("result", 64'(result), 64'(e32));
            end
         end
         pv_prev = i_TVALID;
         px_prev = px;
         bv_prev = b_TVALID;
         bx_prev = bx;
         dn_prev = done;
         pi_prev = i_TDATA;
         pk_prev = k_TDATA;
         pb_prev = b_TDATA;
      end
   end

   // ---------------- stimulus ----------------
   task automatic write_pair(input logic [7:0] a, input logic [7:0] b);
      wr_i  = a;
      wr_k  = b;
      wr_en = 1'b1;
      if (mcnt < 16) begin
         exp_i.push_back(a);
         exp_k.push_back(b);
         mcnt++;
      end
      @(posedge clk);
      #1 wr_en = 1'b0;
   endtask

   task automatic clear_model();
      exp_i.delete();
      exp_k.delete();
      exp_b.delete();
      exp_r.delete();
      mcnt = 0;
   endtask

   task automatic run_job(input logic [7:0] bv, input logic [31:0] ov,
                          input logic [7:0] pat, input int plen,
                          input int bdly, input bit inject);
      int cyc;
      bias  = bv;
      start = 1'b1;
      exp_b.push_back(bv);
      @(posedge clk);
      #1 start = 1'b0;
      check("start_busy", 64'(busy), 64'(1));
      check("start_valids", 64'({b_TVALID, i_TVALID, k_TVALID, new_i}),
            64'(4'hF));
      cyc = 0;
      while (!o_TREADY && cyc < 300) begin
         i_TREADY = pat[cyc % plen];
         k_TREADY = pat[cyc % plen];
         b_TREADY = (cyc >= bdly);
         if (inject) begin
            wr_en = (cyc == 1);
            start = (cyc == 1);
            wr_i  = 8'hEE;
            wr_k  = 8'hEE;
         end
         @(posedge clk);
         #1 cyc++;
      end
      wr_en    = 1'b0;
      start    = 1'b0;
      i_TREADY = 1'b1;
      k_TREADY = 1'b1;
      b_TREADY = 1'b1;
      if (cyc >= 300) begin
         check("timeout_o_TREADY", 64'(o_TREADY), 64'(1));
         return;
      end
      check("all_sent", 64'(exp_i.size() + exp_b.size()), 64'(0));
      o_TDATA  = ov;
      o_TVALID = 1'b1;
      exp_r.push_back(ov);
      @(posedge clk);
      #1 o_TVALID = 1'b0;
      mcnt = 0;
      check("done_rise", 64'({done, busy, o_TREADY}), 64'(3'b100));
      @(posedge clk);
      #1;
      check("done_fall", 64'(done), 64'(0));
      check("result_popped", 64'(exp_r.size()), 64'(0));
      check("result_hold", 64'(result), 64'(ov));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected finish");
      $fatal(1);
   end

   initial begin
      reset    = 1'b1;
      wr_en    = 1'b0;
      wr_i     = '0;
      wr_k     = '0;
      bias     = '0;
      start    = 1'b0;
      i_TREADY = 1'b1;
      k_TREADY = 1'b1;
      b_TREADY = 1'b1;
      o_TDATA  = '0;
      o_TVALID = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      check("reset_state",
            64'({busy, done, wr_full, b_TVALID, i_TVALID, k_TVALID,
                 new_i, o_TREADY, result}), 64'(0));

      // fill, then async reset mid-cycle
      for (int n = 0; n < 16; n++) begin
         write_pair(8'(n), 8'(n + 100));
         if (n == 14) check("not_full_15", 64'(wr_full), 64'(0));
      end
      check("full_16", 64'(wr_full), 64'(1));
      #3 reset = 1'b1;
      #1;
      check("async_reset_ctl",
            64'({busy, done, wr_full, b_TVALID, i_TVALID, k_TVALID,
                 new_i, o_TREADY}), 64'(0));
      check("async_reset_data",
            64'({result, i_TDATA, k_TDATA, b_TDATA}), 64'(0));
      clear_model();
      @(posedge clk);
      #1 reset = 1'b0;

      // basic job
      write_pair(8'd1, 8'd2);
      write_pair(8'd3, 8'd4);
      write_pair(8'd5, 8'd6);
      run_job(8'd7, 32'd51, 8'hFF, 1, 0, 1'b0);

      // backpressure: i/k ready 1,0,0,1,1; bias ready after 3 cycles
      write_pair(8'd1, 8'd2);
      write_pair(8'd3, 8'd4);
      write_pair(8'd5, 8'd6);
      run_job(8'd7, 32'h0000_1234, 8'b0001_1001, 5, 3, 1'b0);

      // full buffer, 17th write dropped
      for (int n = 0; n < 17; n++) begin
         write_pair(8'(n), 8'(8'hF0 ^ n));
         if (n == 15) check("full_after_16", 64'(wr_full), 64'(1));
      end
      check("full_after_17", 64'(wr_full), 64'(1));
      run_job(8'h55, 32'hDEAD_BEEF, 8'hFF, 1, 0, 1'b0);
      check("empty_after_job", 64'(wr_full), 64'(0));

      // start on empty buffer is ignored
      bias  = 8'h09;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      check("empty_start", 64'({busy, b_TVALID, i_TVALID}), 64'(0));

      // start with same-cycle write: write accepted, start ignored
      start = 1'b1;
      write_pair(8'h09, 8'h08);
      start = 1'b0;
      check("start_wr_same", 64'({busy, b_TVALID}), 64'(0));
      write_pair(8'h11, 8'h22);
      run_job(8'h33, 32'd77, 8'b01, 2, 1, 1'b1);

      // reset after 2 of 4 pairs
      write_pair(8'hA0, 8'hB0);
      write_pair(8'hA1, 8'hB1);
      write_pair(8'hA2, 8'hB2);
      write_pair(8'hA3, 8'hB3);
      bias  = 8'h44;
      start = 1'b1;
      exp_b.push_back(8'h44);
      @(posedge clk);
      #1 start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      check("two_pairs_gone", 64'(exp_i.size()), 64'(2));
      reset = 1'b1;
      #1;
      check("midjob_reset",
            64'({busy, b_TVALID, i_TVALID, k_TVALID, new_i, o_TREADY,
                 i_TDATA, k_TDATA}), 64'(0));
      clear_model();
      @(posedge clk);
      #1 reset = 1'b0;
      check("reset_empty", 64'({wr_full, busy}), 64'(0));
      write_pair(8'h5A, 8'hA5);
      run_job(8'h01, 32'h0000_CAFE, 8'hFF, 1, 0, 1'b0);

      repeat (2) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
